// File: rtl/encoder_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : encoder_emulator
//  Purpose  : Code-disk / opto emulator. Generates the opto pulse stream of a
//             TOOTH_NUM-slot disk carrying TOOTH_NUM-1 physical teeth. Tooth 0
//             is the double-width zero tooth. The model includes a motor
//             spin-up ramp, settle/lock indication, speed changes while
//             running, and missing-tooth fault injection.
//  Ports    : i_clk          system clock
//             i_rst          synchronous reset, active-high
//             i_enable       1 = motor running, 0 = stop (returns to IDLE)
//             i_slot_clks    target slot period in clocks (0 = default,
//                            1..3 clamp to 4)
//             i_drop_tooth   suppress the tooth that starts in this cycle
//             o_opto         opto level, high for first half of each tooth
//             o_opto_rise    1-clk pulse at each tooth start
//             o_zero_sign    1-clk pulse at zero-tooth start
//             o_motor_state  speed locked
//             o_tooth_idx    current tooth (0 = zero tooth)
//             o_rev_cnt      completed-revolution count, wraps
//  Revision : 1.0  initial release
// ============================================================================
module encoder_emulator #(
  parameter int unsigned CLK_PERIOD_NS = 10,
  parameter int unsigned MOTOR_FREQ    = 100,
  parameter int unsigned TOOTH_NUM     = 100,
  parameter int unsigned DEF_SLOT_CLKS = 1_000_000_000 / MOTOR_FREQ / TOOTH_NUM / CLK_PERIOD_NS,
  parameter int unsigned LOCK_REVS     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic [23:0] i_slot_clks,
  input  logic        i_drop_tooth,
  output logic        o_opto,
  output logic        o_opto_rise,
  output logic        o_zero_sign,
  output logic        o_motor_state,
  output logic [7:0]  o_tooth_idx,
  output logic [15:0] o_rev_cnt
);

  localparam logic [23:0] c_def_slot  = 24'(DEF_SLOT_CLKS);
  localparam logic [7:0]  c_idx_last  = 8'(TOOTH_NUM - 2);
  localparam logic [15:0] c_lock_revs = 16'(LOCK_REVS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RAMP   = 2'd1,
    S_SETTLE = 2'd2,
    S_RUN    = 2'd3
  } state_e;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [24:0] cnt_q,    cnt_d;     // position inside the current tooth
  logic [7:0]  idx_q,    idx_d;     // current tooth index
  logic [23:0] cur_q,    cur_d;     // slot period in force this revolution
  logic [23:0] tgt_q,    tgt_d;     // target period sampled at zero tooth
  logic [15:0] settle_q, settle_d;  // revolutions spent at target speed
  logic [15:0] rev_q,    rev_d;
  logic        motor_q,  motor_d;
  logic        drop_q,   drop_d;    // current tooth is suppressed

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [23:0] w_eff;        // clamped / defaulted target period
  logic [23:0] w_eff_x4;     // ramp start period
  logic [24:0] w_tooth_len;
  logic        w_running;
  logic        w_tooth_start;
  logic        w_tooth_end;
  logic [7:0]  w_next_idx;
  logic        w_next_zero;
  logic [23:0] w_ramp_step;
  logic [24:0] w_ramp_floor;
  logic [23:0] w_ramp_cur;
  logic        w_drop_now;
  logic [15:0] w_settle_inc;

  always_comb begin
    if (i_slot_clks == 24'd0) begin
      w_eff = c_def_slot;
    end else if (i_slot_clks < 24'd4) begin
      w_eff = 24'd4;
    end else begin
      w_eff = i_slot_clks;
    end
  end

  // The 4x start period saturates rather than wrapping for huge targets.
  assign w_eff_x4 = (w_eff[23:22] != 2'b00) ? 24'hFF_FFFF : {w_eff[21:0], 2'b00};

  assign w_running     = (state_q != S_IDLE);
  assign w_tooth_len   = (idx_q == 8'd0) ? {cur_q, 1'b0} : {1'b0, cur_q};
  assign w_tooth_start = w_running && (cnt_q == 25'd0);
  assign w_tooth_end   = (cnt_q == (w_tooth_len - 25'd1));
  assign w_next_idx    = (idx_q == c_idx_last) ? 8'd0 : (idx_q + 8'd1);
  assign w_next_zero   = (w_next_idx == 8'd0);
  assign w_settle_inc  = settle_q + 16'd1;

  // Ramp: cur steps down by a quarter of the target each revolution and is
  // floored at the target. Compare in 25 bits so the subtraction never
  // underflows and the sum never overflows.
  assign w_ramp_step  = w_eff >> 2;
  assign w_ramp_floor = {1'b0, w_eff} + {1'b0, w_ramp_step};
  assign w_ramp_cur   = ({1'b0, cur_q} <= w_ramp_floor) ? w_eff : (cur_q - w_ramp_step);

  // A drop request is only honoured in the tooth-start cycle; from then on
  // the latched flag blanks the rest of that tooth.
  assign w_drop_now = w_tooth_start ? i_drop_tooth : drop_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    cur_d    = cur_q;
    tgt_d    = tgt_q;
    settle_d = settle_q;
    rev_d    = rev_q;
    motor_d  = motor_q;
    drop_d   = drop_q;

    if (!i_enable) begin
      // Stop is immediate: no partial tooth is completed.
      state_d  = S_IDLE;
      cnt_d    = 25'd0;
      idx_d    = 8'd0;
      cur_d    = 24'd0;
      tgt_d    = 24'd0;
      settle_d = 16'd0;
      rev_d    = 16'd0;
      motor_d  = 1'b0;
      drop_d   = 1'b0;
    end else if (state_q == S_IDLE) begin
      // Next cycle is the start of the zero tooth at 4x target period.
      state_d  = S_RAMP;
      cnt_d    = 25'd0;
      idx_d    = 8'd0;
      tgt_d    = w_eff;
      cur_d    = w_eff_x4;
      settle_d = 16'd0;
      rev_d    = 16'd0;
      motor_d  = 1'b0;
      drop_d   = 1'b0;
    end else begin
      drop_d = w_drop_now;
      if (!w_tooth_end) begin
        cnt_d = cnt_q + 25'd1;
      end else begin
        cnt_d = 25'd0;
        idx_d = w_next_idx;
        if (w_next_zero) begin
          // Revolution bookkeeping happens on the edge entering the zero
          // tooth, so the new period already governs the zero tooth itself.
          rev_d = rev_q + 16'd1;
          tgt_d = w_eff;
          case (state_q)
            S_RAMP: begin
              cur_d = w_ramp_cur;
              if (w_ramp_cur == w_eff) begin
                state_d  = S_SETTLE;
                settle_d = 16'd0;
              end
            end
            S_SETTLE: begin
              if (w_eff != tgt_q) begin
                cur_d    = w_eff;
                settle_d = 16'd0;
              end else begin
                settle_d = w_settle_inc;
                if (w_settle_inc >= c_lock_revs) begin
                  state_d = S_RUN;
                  motor_d = 1'b1;
                end
              end
            end
            S_RUN: begin
              if (w_eff != tgt_q) begin
                cur_d    = w_eff;
                motor_d  = 1'b0;
                settle_d = 16'd0;
                state_d  = S_SETTLE;
              end
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 25'd0;
      idx_q    <= 8'd0;
      cur_q    <= 24'd0;
      tgt_q    <= 24'd0;
      settle_q <= 16'd0;
      rev_q    <= 16'd0;
      motor_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      cur_q    <= cur_d;
      tgt_q    <= tgt_d;
      settle_q <= settle_d;
      rev_q    <= rev_d;
      motor_q  <= motor_d;
      drop_q   <= drop_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_opto_rise   = w_tooth_start && !i_drop_tooth;
  assign o_zero_sign   = o_opto_rise && (idx_q == 8'd0);
  assign o_opto        = w_running && (cnt_q < (w_tooth_len >> 1)) && !w_drop_now;
  assign o_motor_state = motor_q;
  assign o_tooth_idx   = idx_q;
  assign o_rev_cnt     = rev_q;

endmodule
`default_nettype wire

// File: tb/tb_encoder_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_encoder_emulator
//  Purpose  : Scoreboard bench for encoder_emulator. Stimulus pushes expected
//             zero-sign and tooth records; monitors pop and compare them as
//             the DUT produces zero signs and tooth rises.
//  Revision : 1.0  initial release
// ============================================================================
module tb_encoder_emulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] slot;
  logic        drop;
  logic        o_opto, o_opto_rise, o_zero_sign, o_motor_state;
  logic [7:0]  o_tooth_idx;
  logic [15:0] o_rev_cnt;

  always #5 clk = ~clk;

  encoder_emulator dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_enable      (en),
    .i_slot_clks   (slot),
    .i_drop_tooth  (drop),
    .o_opto        (o_opto),
    .o_opto_rise   (o_opto_rise),
    .o_zero_sign   (o_zero_sign),
    .o_motor_state (o_motor_state),
    .o_tooth_idx   (o_tooth_idx),
    .o_rev_cnt     (o_rev_cnt)
  );

  typedef struct {
    int          spacing;   // clocks since previous zero sign, -1 = don't care
    int          rises;     // rises in previous revolution, -1 = don't care
    logic        motor;
    logic [15:0] rev;
  } zs_t;

  typedef struct {
    int idx;
    int high;
    int len;
  } tooth_t;

  zs_t    zq[$];
  tooth_t tq[$];

  int total = 0;
  int bad   = 0;
  int rise_total = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event", nm);
  endfunction

  function automatic void push_zs(input int sp, input int rs, input logic m, input int rv);
    zs_t e;
    e.spacing = sp;
    e.rises   = rs;
    e.motor   = m;
    e.rev     = 16'(rv);
    zq.push_back(e);
  endfunction

  function automatic void push_tooth(input int i, input int h, input int l);
    tooth_t t;
    t.idx  = i;
    t.high = h;
    t.len  = l;
    tq.push_back(t);
  endfunction

  // --------------------------------------------------------------------------
  // Zero-sign monitor
  // --------------------------------------------------------------------------
  int cyc = 0;
  int last_zs_cyc = 0;
  int rises_rev = 0;

  always @(negedge clk) begin
    cyc++;
    if (o_opto_rise === 1'b1) rise_total++;
    if (o_zero_sign === 1'b1) begin
      if (zq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL zero_sign: got unexpected pulse at cycle %0d expected none", cyc);
      end else begin
        zs_t e;
        e = zq.pop_front();
        total++;
        if (((e.spacing >= 0) && ((cyc - last_zs_cyc) != e.spacing)) ||
            ((e.rises >= 0) && (rises_rev != e.rises)) ||
            (o_motor_state !== e.motor) || (o_rev_cnt !== e.rev)) begin
          bad++;
          $display("FAIL zero_sign rev%0d: got spacing=%0d rises=%0d motor=%0b rev=%0d expected spacing=%0d rises=%0d motor=%0b rev=%0d",
                   e.rev, cyc - last_zs_cyc, rises_rev, o_motor_state, o_rev_cnt,
                   e.spacing, e.rises, e.motor, e.rev);
        end
      end
      last_zs_cyc = cyc;
      rises_rev   = 0;
    end
    if (o_opto_rise === 1'b1) rises_rev++;
  end

  // --------------------------------------------------------------------------
  // Tooth monitor: a tooth record runs from one rise to the next, so a
  // dropped tooth folds into the record of the tooth before it.
  // --------------------------------------------------------------------------
  bit have = 0;
  bit synced = 0;
  int t_idx = 0;
  int t_high = 0;
  int t_len = 0;

  always @(negedge clk) begin
    if (o_opto_rise === 1'b1) begin
      if (have && (tq.size() > 0)) begin
        if (!synced && (tq[0].idx == t_idx)) synced = 1;
        if (synced) begin
          tooth_t t;
          t = tq.pop_front();
          total++;
          if ((t.idx != t_idx) || (t.high != t_high) || (t.len != t_len)) begin
            bad++;
            $display("FAIL tooth%0d: got idx=%0d high=%0d len=%0d expected idx=%0d high=%0d len=%0d",
                     t.idx, t_idx, t_high, t_len, t.idx, t.high, t.len);
          end
          if (tq.size() == 0) synced = 0;
        end
      end
      have   = 1;
      t_idx  = int'(o_tooth_idx);
      t_high = 0;
      t_len  = 0;
    end
    if (have) begin
      t_len++;
      if (o_opto === 1'b1) t_high++;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_zs(input int bound, input string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((o_zero_sign !== 1'b1) && (n < bound));
    if (o_zero_sign !== 1'b1) timeout(nm);
  endtask

  task automatic wait_idx(input logic [7:0] idx, input int bound);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((o_tooth_idx !== idx) && (n < bound));
    if (o_tooth_idx !== idx) timeout("wait_tooth_idx");
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_opto"},  32'(o_opto), 32'd0);
    chk({nm, "_rise"},  32'(o_opto_rise), 32'd0);
    chk({nm, "_zero"},  32'(o_zero_sign), 32'd0);
    chk({nm, "_motor"}, 32'(o_motor_state), 32'd0);
    chk({nm, "_idx"},   32'(o_tooth_idx), 32'd0);
    chk({nm, "_rev"},   32'(o_rev_cnt), 32'd0);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int n;
    rst  = 1'b1;
    en   = 1'b0;
    slot = 24'd0;
    drop = 1'b0;

    // Reset and idle
    clks(3);
    chk_all_zero("reset");
    rst = 1'b0;
    clks(1000);
    chk_all_zero("idle");
    chk("idle_rise_count", 32'(rise_total), 32'd0);

    // Ramp at period 8: 32,30,...,8 (13 revolutions), settle, lock on 15th
    push_zs(-1, -1, 1'b0, 0);
    for (int k = 2; k <= 13; k++) push_zs(100 * (32 - 2 * (k - 2)), 99, 1'b0, k - 1);
    push_zs(800, 99, 1'b0, 13);
    push_zs(800, 99, 1'b1, 14);
    slot = 24'd8;
    en   = 1'b1;
    clks(1);
    chk("enable_zero_sign", 32'(o_zero_sign), 32'd1);
    for (int k = 2; k <= 15; k++) wait_zs(4000, "wait_ramp_zs");

    // Speed change 8 -> 40 while locked: period holds until next zero sign
    clks(100);
    slot = 24'd40;
    push_zs(800,  99, 1'b0, 15);
    push_zs(4000, 99, 1'b0, 16);
    push_zs(4000, 99, 1'b1, 17);
    for (int k = 0; k < 3; k++) wait_zs(6000, "wait_relock_zs");

    // One locked revolution at 40 with tooth 5 dropped
    push_tooth(0, 40, 80);
    for (int i = 1; i <= 3; i++) push_tooth(i, 20, 40);
    push_tooth(4, 20, 80);
    for (int i = 6; i <= 98; i++) push_tooth(i, 20, 40);
    push_zs(4000, 98, 1'b1, 18);
    wait_idx(8'd5, 1000);
    drop = 1'b1;
    clks(1);
    drop = 1'b0;
    wait_zs(6000, "wait_drop_rev_zs");

    // Speed change 40 -> 50 mid-revolution
    clks(1000);
    slot = 24'd50;
    push_zs(4000, 99, 1'b0, 19);
    push_zs(5000, 99, 1'b0, 20);
    push_zs(5000, 99, 1'b1, 21);
    for (int k = 0; k < 3; k++) wait_zs(6000, "wait_speed50_zs");

    // Mid-tooth stop, then restart from 4x period
    clks(1234);
    en = 1'b0;
    clks(1);
    chk_all_zero("stop");
    clks(10);
    push_zs(-1, -1, 1'b0, 0);
    push_tooth(0, 200, 400);
    push_tooth(1, 100, 200);
    en = 1'b1;
    clks(1);
    chk("restart_rise", 32'(o_opto_rise), 32'd1);
    chk("restart_zero", 32'(o_zero_sign), 32'd1);
    chk("restart_idx",  32'(o_tooth_idx), 32'd0);

    n = 0;
    while ((tq.size() != 0) && (n < 2000)) begin
      clks(1);
      n++;
    end
    clks(5);
    chk("tooth_queue_left", 32'(tq.size()), 32'd0);
    chk("zero_queue_left",  32'(zq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/encoder_emulator.md
Name: encoder_emulator

Overview:
Synthesizable code-disk/opto emulator that produces the opto pulse stream consumed by the angle-sync logic: o_opto_rise, o_zero_sign and o_motor_state. Models a 100-slot disk with 98 normal teeth and 1 double-width zero tooth, with motor spin-up ramp, settle/lock indication, runtime speed change and missing-tooth fault injection. Sits in the rotate/encoder area and drives the encoder inputs during bench bring-up and built-in self-test.

Parameters:
CLK_PERIOD_NS, 10, i_clk period in ns
MOTOR_FREQ, 100, nominal revolutions per second
TOOTH_NUM, 100, disk slots per revolution; zero tooth occupies 2 slots, so TOOTH_NUM-1 physical teeth
DEF_SLOT_CLKS, 1_000_000_000/MOTOR_FREQ/TOOTH_NUM/CLK_PERIOD_NS (=10000), slot period used when i_slot_clks==0
LOCK_REVS, 2, full revolutions at target speed before o_motor_state asserts

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_enable  in  1  1 = motor running; 0 = stop
i_slot_clks  in  24  target slot period in clocks; 0 selects DEF_SLOT_CLKS; values 1..3 clamp to 4
i_drop_tooth  in  1  fault inject: suppress the tooth starting this cycle
o_opto  out  1  opto level, high for first half of each tooth
o_opto_rise  out  1  1-clk pulse at each tooth start
o_zero_sign  out  1  1-clk pulse at zero-tooth start, coincident with o_opto_rise
o_motor_state  out  1  speed locked
o_tooth_idx  out  8  current tooth, 0 = zero tooth, 1..TOOTH_NUM-2 normal
o_rev_cnt  out  16  completed-revolution count, wraps

Behaviour:
- Reset, or i_enable=0 in any state: next cycle state=IDLE; all outputs 0; counters and latched periods cleared. No partial-tooth completion.
- States: IDLE, RAMP, SETTLE, RUN.
- IDLE: i_enable=1 -> RAMP. Next cycle = tooth 0 start: o_opto_rise=o_zero_sign=1, tgt=effective i_slot_clks, cur=tgt<<2.
- Tooth length: zero tooth 2*cur clocks, normal tooth cur clocks. Slot counter runs 0..len-1. o_opto=1 for counter < len>>1. Tooth start at counter=0. Idx wraps TOOTH_NUM-2 -> 0.
- One revolution = TOOTH_NUM*cur clocks. o_rev_cnt increments at each zero-tooth start except the first after IDLE.
- i_slot_clks is sampled only at zero-tooth start; mid-revolution changes take effect next revolution. cur is also updated only there.
- RAMP, at each zero-tooth start after the first: cur = max(tgt, cur-(tgt>>2)). If the resulting cur==tgt -> SETTLE, with settle counter cleared.
- SETTLE: settle counter increments at each zero-tooth start. When it reaches LOCK_REVS -> RUN, and o_motor_state=1 in the same cycle as that o_zero_sign.
- RUN: if a newly sampled tgt differs from the previous tgt: cur=tgt immediately, o_motor_state=0 the same cycle, -> SETTLE.
- i_drop_tooth=1 on a tooth-start cycle:
  - o_opto_rise, o_zero_sign and o_opto are held 0 for that whole tooth.
  - Tooth index, timing, rev count and state machine advance normally.
  - A dropped zero tooth still performs the ramp/settle/rev bookkeeping.
  - Asserting it on non-start cycles has no effect.
- Arithmetic: 24-bit period; zero-tooth length is 25-bit. o_rev_cnt is 16-bit and wraps 0xFFFF->0.

Test Plan:
1. Reset/idle: i_rst=1 for 3 clks, i_enable=0 -> all outputs 0; o_opto_rise never pulses over 1000 clks.
2. Ramp/lock (TOOTH_NUM=100, i_slot_clks=40, LOCK_REVS=2):
   - Enable -> per-revolution periods 160,150,...,40 (13 revolutions).
   - SETTLE is entered at the 13th zero sign.
   - o_motor_state rises with the 15th o_zero_sign.
   - Zero-sign spacing = 100*cur clocks.
3. Tooth shape in RUN, period 40:
   - Zero tooth: opto high 40 / low 40.
   - Normal tooth: high 20 / low 20.
   - 99 o_opto_rise pulses and 1 o_zero_sign per 4000 clks.
   - o_tooth_idx cycles 0..98.
4. Speed change in RUN: i_slot_clks 40->50 mid-revolution:
   - Period stays 40 until the next zero sign.
   - At that zero sign: o_motor_state=0, period=50.
   - o_motor_state re-asserts 2 revolutions later.
5. Fault: i_drop_tooth pulsed at the start of tooth 5 -> no rise or opto high for tooth 5; tooth 6 starts on schedule; o_rev_cnt unaffected.
6. Mid-run stop: i_enable=0 mid-tooth -> next cycle all outputs 0. Re-enable -> immediate zero sign, ramp restarts from 4x period.
